// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// The package is named fifo_arb_pkg.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    function automatic int owner_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above last_owner, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = owner_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic               found,
    output logic [ID_W-1:0]    pick_id
);

    logic [NUM_REQ-1:0] rot;
    int                 sum;

    // rot[j] is requester (last_owner+1+j) mod NUM_REQ; lowest j wins
    always_comb begin
        found   = 1'b0;
        pick_id = last_owner;
        sum     = 0;
        rot     = NUM_REQ'({req, req} >> (int'(last_owner) + 1));
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j[ID_W-1:0]]) begin
                found = 1'b1;
                sum   = int'(last_owner) + 1 + j;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                pick_id = ID_W'(sum);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between NUM_REQ burst requesters.
// Optional statistics outputs are enabled with `define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                         w_clk,
    input  logic                         w_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         w_full,
    output logic                         w_en,
    output logic [DATA_SIZE-1:0]         w_data,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]    stat_beats,
    output logic [STAT_W-1:0]            stat_full_stall
`endif
);

    localparam int              ID_W      = $clog2(NUM_REQ);
    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  pick_id;
    logic [CNT_W-1:0] beat_cnt;
    logic             found;
    logic             owner_valid;
    logic             owner_last;
    logic             release_burst;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (req_valid),
        .last_owner (owner),
        .found      (found),
        .pick_id    (pick_id)
    );

    // owner doubles as last_owner: it is only rewritten at a new grant
    assign owner_valid   = req_valid[owner];
    assign owner_last    = req_last[owner];
    assign release_burst = w_en && (owner_last || (beat_cnt == LAST_BEAT));
    assign grant_id      = owner;

    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = LOCK;
            LOCK:    if (release_burst) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        w_en      = 1'b0;
        busy      = (state == LOCK);
        if (state == LOCK) begin
            req_ready[owner] = !w_full;
            w_en             = owner_valid && !w_full;
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == ID_W'(i)) begin
                w_data = req_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            owner    <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else if ((state == IDLE) && found) begin
            owner    <= pick_id;
            beat_cnt <= '0;
        end else if (release_burst) begin
            beat_cnt <= '0;
        end else if (w_en) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_SAT = '1;

    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            stat_beats      <= '0;
            stat_full_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_en && (owner == ID_W'(i)) &&
                    (stat_beats[i*STAT_W +: STAT_W] != STAT_SAT)) begin
                    stat_beats[i*STAT_W +: STAT_W] <= stat_beats[i*STAT_W +: STAT_W] + 1'b1;
                end
            end
            if ((state == LOCK) && owner_valid && w_full && (stat_full_stall != STAT_SAT)) begin
                stat_full_stall <= stat_full_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requester queues, a burst-level round-robin schedule and per-cycle checks.
module tb_fifo_wr_arbiter;

    localparam int NR     = 4;
    localparam int DW     = 8;
    localparam int MB     = 8;
    localparam int BUDGET = 3000;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } beat_t;

    typedef struct packed {
        int owner;
        int len;
    } chunk_t;

    logic             w_clk = 1'b0;
    logic             w_rst = 1'b0;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_last;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             w_full;
    logic             w_en;
    logic [DW-1:0]    w_data;
    logic [1:0]       grant_id;
    logic             busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [NR*16-1:0] stat_beats;
    logic [15:0]      stat_full_stall;
`endif

    int     checks = 0;
    int     errors = 0;
    beat_t  bq [NR][$];
    chunk_t chunks [$];
    int     grant_log [$];
    int     model_last;
    int     exp_beats [NR];
    int     exp_stall;
    int     full_mode;
    int     stall_at;
    int     stall_left;
    int     run_cycles;
    int     obs_stall;
    int     exp_order [5] = '{0, 1, 2, 3, 0};
    int     split_order [4] = '{2, 1, 2, 2};

    always #5 w_clk = ~w_clk;

    fifo_wr_arbiter #(
        .DATA_SIZE (DW),
        .NUM_REQ   (NR),
        .MAX_BURST (MB)
    ) dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .w_full    (w_full),
        .w_en      (w_en),
        .w_data    (w_data),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_beats      (stat_beats),
        .stat_full_stall (stat_full_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (bq[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_last[i]           = bq[i][0].last;
                req_data[i*DW +: DW]  = bq[i][0].d;
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic add_burst(input int r, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d    = DW'($urandom);
            b.last = (k == len - 1);
            bq[r].push_back(b);
        end
    endtask

    task automatic clear_model_stats();
        for (int i = 0; i < NR; i++) exp_beats[i] = 0;
        exp_stall = 0;
    endtask

    // Split every queued burst into grants of at most MB beats, served round-robin
    task automatic build_chunks(input int last_in);
        int     p [NR];
        int     last;
        int     r;
        int     len;
        bit     any;
        chunk_t c;
        last = last_in;
        chunks.delete();
        for (int i = 0; i < NR; i++) p[i] = 0;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            r   = 0;
            for (int s = NR; s >= 1; s--) begin
                if (p[(last + s) % NR] < bq[(last + s) % NR].size()) begin
                    any = 1'b1;
                    r   = (last + s) % NR;
                end
            end
            if (any) begin
                len = 1;
                while (!bq[r][p[r] + len - 1].last && len < MB) len++;
                c.owner = r;
                c.len   = len;
                chunks.push_back(c);
                p[r] += len;
                last = r;
            end
        end
    endtask

    task automatic check_stats();
`ifdef FIFO_WR_ARB_STATS_EN
        for (int r = 0; r < NR; r++)
            check($sformatf("stat_beats%0d", r), 32'(stat_beats[r*16 +: 16]), exp_beats[r]);
        check("stat_full_stall", 32'(stat_full_stall), exp_stall);
`endif
    endtask

    // Expects the DUT idle with the queued requests already visible on its inputs
    task automatic run(input int stop_beats);
        int            ci = 0;
        int            bd = 0;
        int            beats = 0;
        int            cyc = 0;
        int            owner;
        int            prev;
        bit            bubble = 1'b1;
        bit            new_chunk = 1'b0;
        logic [NR-1:0] exp_ready;
        beat_t         b;
        build_chunks(model_last);
        prev      = model_last;
        obs_stall = 0;
        while (ci < chunks.size() && cyc < BUDGET) begin
            owner = chunks[ci].owner;
            case (full_mode)
                1:       w_full = ($urandom_range(0, 9) < 3);
                2: begin
                    w_full = !bubble && (beats >= stall_at) && (stall_left > 0);
                    if (w_full) stall_left--;
                end
                default: w_full = 1'b0;
            endcase
            @(negedge w_clk);
            cyc++;
            if (bubble) begin
                check("idle_busy", busy, 0);
                check("idle_w_en", w_en, 0);
                check("idle_ready", req_ready, 0);
                check("idle_grant", grant_id, prev);
            end else begin
                exp_ready = '0;
                if (!w_full) exp_ready[owner] = 1'b1;
                if (new_chunk) begin
                    grant_log.push_back(int'(grant_id));
                    new_chunk = 1'b0;
                end
                check("lock_busy", busy, 1);
                check("lock_grant", grant_id, owner);
                check("lock_ready", req_ready, exp_ready);
                check("lock_w_en", w_en, !w_full);
                if (!w_full) check("w_data", w_data, bq[owner][0].d);
                else begin
                    exp_stall++;
                    if (busy && !w_en) obs_stall++;
                end
            end
            @(posedge w_clk);
            #1;
            if (bubble) begin
                bubble    = 1'b0;
                new_chunk = 1'b1;
            end else if (!w_full) begin
                b = bq[owner].pop_front();
                exp_beats[owner]++;
                bd++;
                beats++;
                if (bd == chunks[ci].len) begin
                    prev   = owner;
                    ci++;
                    bd     = 0;
                    bubble = 1'b1;
                end
            end
            drive_inputs();
            if (stop_beats > 0 && beats == stop_beats) begin
                run_cycles = cyc;
                return;
            end
        end
        check("run_complete", ci, chunks.size());
        model_last = prev;
        run_cycles = cyc;
        w_full     = 1'b0;
        check_stats();
    endtask

    initial begin
        w_full    = 1'b0;
        full_mode = 0;
        stall_at  = 0;
        stall_left = 0;
        clear_model_stats();
        drive_inputs();

        // Reset state
        repeat (3) @(posedge w_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_w_en", w_en, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant_id, NR - 1);
        w_rst      = 1'b1;
        model_last = NR - 1;
        check_stats();

        // All four requesters, 2-beat bursts: grants 0,1,2,3,0
        for (int r = 0; r < NR; r++) add_burst(r, 2);
        add_burst(0, 2);
        drive_inputs();
        grant_log.delete();
        run(0);
        for (int k = 0; k < 5; k++)
            check($sformatf("rr_order%0d", k), grant_log.size() > k ? grant_log[k] : -1, exp_order[k]);

        // Make requester 1 the last owner, then a 20-beat burst from 2 split by MAX_BURST
        add_burst(1, 1);
        drive_inputs();
        run(0);
        add_burst(2, 20);
        add_burst(1, 4);
        drive_inputs();
        grant_log.delete();
        run(0);
        for (int k = 0; k < 4; k++)
            check($sformatf("split_order%0d", k), grant_log.size() > k ? grant_log[k] : -1, split_order[k]);

        // w_full held for 5 cycles mid-burst
        add_burst(0, 8);
        drive_inputs();
        full_mode  = 2;
        stall_at   = 3;
        stall_left = 5;
        run(0);
        check("full_stall_cycles", obs_stall, 5);
        check("full_run_cycles", run_cycles, 1 + 8 + 5);
        full_mode = 0;

        // Random bursts with random backpressure
        full_mode = 1;
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < NR; r++) begin
                int nb;
                nb = $urandom_range(1, 3);
                for (int k = 0; k < nb; k++) add_burst(r, $urandom_range(1, 12));
            end
            drive_inputs();
            run(0);
        end
        full_mode = 0;

        // Single requester 3, back-to-back 1-beat bursts: one beat every other cycle
        for (int k = 0; k < 6; k++) add_burst(3, 1);
        drive_inputs();
        run(0);
        check("single_req_cycles", run_cycles, 12);

        // Reset asserted while the third beat of a burst is presented
        add_burst(1, 5);
        add_burst(2, 2);
        drive_inputs();
        run(2);
        check("pre_rst_busy", busy, 1);
        w_rst = 1'b0;
        @(posedge w_clk);
        #1;
        w_rst = 1'b1;
        bq[1].delete();
        add_burst(1, 3);
        drive_inputs();
        clear_model_stats();
        model_last = NR - 1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_w_en", w_en, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_grant", grant_id, NR - 1);
        check_stats();
        grant_log.delete();
        run(0);
        check("post_rst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
